mult_seq_param: RTL and testbench

//  Parametrised sequential shift/add multiplier on one clock with a start/finish handshake.

---
 rtl/mult_pkg.sv | 9 +
 rtl/mult_seq_dp.sv | 40 ++++
 rtl/mult_seq_param.sv | 52 +++++
 tb/tb_mult_seq_param.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM states and magnitude helper for the sequential multiplier
package mult_pkg;
  localparam int MAX_W = 64;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} state_t;
  // value is zero-extended; the low width bits of the result hold |value| even for -2^(width-1)
  function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] value, input logic sgn, input int width);
    return (sgn && value[width-1]) ? ~value + MAX_W'(1) : value;
  endfunction
endpackage

// File: rtl/mult_seq_dp.sv
// mult_seq_dp: shift/add datapath holding multiplicand, multiplier, partial product and result
module mult_seq_dp import mult_pkg::*; #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               fix,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] o,
  output logic               rest_zero
);
  logic [2*WIDTH-1:0] mcand, prod;
  logic [WIDTH-1:0] mplier, mag_a, mag_b;
  logic neg;
  assign mag_a = WIDTH'(abs_w(MAX_W'(a), sgn, WIDTH));
  assign mag_b = WIDTH'(abs_w(MAX_W'(b), sgn, WIDTH));
  assign rest_zero = (mplier >> 1) == '0;
  always_ff @(posedge clk)
    if (reset) begin
      mcand <= '0;
      mplier <= '0;
      prod <= '0;
      neg <= 1'b0;
      o <= '0;
    end else if (load) begin
      mcand <= {{WIDTH{1'b0}}, mag_a};
      mplier <= mag_b;
      prod <= '0;
      neg <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (step) begin
      prod <= prod + (mplier[0] ? mcand : '0);
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
    end else if (fix)
      o <= neg ? -prod : prod;
endmodule

// File: rtl/mult_seq_param.sv
// mult_seq_param: parametrised sequential shift/add multiplier with start/Finish handshake
module mult_seq_param import mult_pkg::*; #(
  parameter int WIDTH      = 4,
  parameter bit EARLY_EXIT = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] O,
  output logic               Finish,
  output logic               busy
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic load, step, fix, rest_zero;
  mult_seq_dp #(.WIDTH(WIDTH)) u_dp (
    .clk(clk),
    .reset(reset),
    .load(load),
    .step(step),
    .fix(fix),
    .sgn(sgn),
    .a(A),
    .b(B),
    .o(O),
    .rest_zero(rest_zero)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= ST_IDLE;
      cnt <= '0;
      Finish <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= load ? '0 : step ? cnt + CW'(1) : cnt;
      Finish <= fix;
    end
  // a zero multiplier under early exit skips RUN entirely; unused encodings fall back to IDLE
  always_comb begin
    load = state == ST_IDLE && start;
    step = state == ST_RUN;
    fix = state == ST_FIX;
    busy = state != ST_IDLE;
    state_nx = load ? ((EARLY_EXIT && B == '0) ? ST_FIX : ST_RUN)
             : step ? ((cnt == CW'(WIDTH - 1) || (EARLY_EXIT && rest_zero)) ? ST_FIX : ST_RUN)
             : ST_IDLE;
  end
endmodule

// File: tb/tb_mult_seq_param.sv
// tb_mult_seq_param: four configurations checked each cycle against an arithmetic reference model
module tb_mult_seq_param;
  logic clk = 0, reset = 1, start = 0, sgn = 0;
  logic [7:0] A = 0, B = 0;
  logic [7:0] o0, o1;
  logic [15:0] o2, o3;
  logic [3:0] fin_d, busy_d;
  logic [15:0] o_d [4];
  int checks = 0, errors = 0;
  bit en = 0;
  int wd [4] = '{4, 4, 8, 8};
  bit eed [4] = '{0, 1, 0, 1};
  logic [15:0] m_o [4] = '{default: '0};
  logic [15:0] m_res [4] = '{default: '0};
  bit m_busy [4] = '{default: 0};
  bit m_fin [4] = '{default: 0};
  int m_left [4] = '{default: 0};

  always #5 clk = ~clk;

  mult_seq_param #(.WIDTH(4), .EARLY_EXIT(0)) u0 (.clk(clk), .reset(reset), .start(start), .sgn(sgn),
    .A(A[3:0]), .B(B[3:0]), .O(o0), .Finish(fin_d[0]), .busy(busy_d[0]));
  mult_seq_param #(.WIDTH(4), .EARLY_EXIT(1)) u1 (.clk(clk), .reset(reset), .start(start), .sgn(sgn),
    .A(A[3:0]), .B(B[3:0]), .O(o1), .Finish(fin_d[1]), .busy(busy_d[1]));
  mult_seq_param #(.WIDTH(8), .EARLY_EXIT(0)) u2 (.clk(clk), .reset(reset), .start(start), .sgn(sgn),
    .A(A), .B(B), .O(o2), .Finish(fin_d[2]), .busy(busy_d[2]));
  mult_seq_param #(.WIDTH(8), .EARLY_EXIT(1)) u3 (.clk(clk), .reset(reset), .start(start), .sgn(sgn),
    .A(A), .B(B), .O(o3), .Finish(fin_d[3]), .busy(busy_d[3]));

  assign o_d[0] = {8'h00, o0};
  assign o_d[1] = {8'h00, o1};
  assign o_d[2] = o2;
  assign o_d[3] = o3;

  function automatic int sval(int w, bit s, logic [7:0] v);
    int m = 1 << w;
    int x = int'(v) & (m - 1);
    return (s && x >= m / 2) ? x - m : x;
  endfunction

  function automatic logic [15:0] ref_prod(int w, bit s, logic [7:0] a, logic [7:0] b);
    longint p = longint'(sval(w, s, a)) * longint'(sval(w, s, b));
    return 16'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // edges from the accepting edge to the edge that raises Finish
  function automatic int ref_lat(int w, bit ee, bit s, logic [7:0] b);
    int mb = sval(w, s, b);
    int p = -1;
    if (mb < 0) mb = -mb;
    for (int j = 0; j < w; j++) if (((mb >> j) & 1) == 1) p = j;
    return !ee ? w + 1 : (mb == 0 ? 1 : p + 2);
  endfunction

  always @(posedge clk)
    for (int i = 0; i < 4; i++) begin
      m_fin[i] = 0;
      if (reset) begin
        m_busy[i] = 0;
        m_o[i] = '0;
      end else if (m_busy[i]) begin
        m_left[i]--;
        if (m_left[i] == 0) begin
          m_busy[i] = 0;
          m_o[i] = m_res[i];
          m_fin[i] = 1;
        end
      end else if (start) begin
        m_busy[i] = 1;
        m_res[i] = ref_prod(wd[i], sgn, A, B);
        m_left[i] = ref_lat(wd[i], eed[i], sgn, B);
      end
    end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (en)
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("o[%0d]", i), o_d[i], m_o[i]);
        chk($sformatf("finish[%0d]", i), 16'(fin_d[i]), 16'(m_fin[i]));
        chk($sformatf("busy[%0d]", i), 16'(busy_d[i]), 16'(m_busy[i]));
      end

  task automatic run_op(input int idx, input bit s, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp_o, input int exp_n, input int exp_busy);
    int n, bc;
    start = 0;
    repeat (12) @(negedge clk);
    sgn = s;
    A = a;
    B = b;
    start = 1;
    @(negedge clk);
    start = 0;
    n = 1;
    bc = int'(busy_d[idx]);
    while (!fin_d[idx] && n < 50) begin
      @(negedge clk);
      n++;
      bc += int'(busy_d[idx]);
    end
    chk($sformatf("op%0d_finish_seen", idx), 16'(fin_d[idx]), 16'd1);
    chk($sformatf("op%0d_product", idx), o_d[idx], exp_o);
    if (exp_n > 0) chk($sformatf("op%0d_latency", idx), 16'(n), 16'(exp_n));
    if (exp_busy > 0) chk($sformatf("op%0d_busy_cycles", idx), 16'(bc), 16'(exp_busy));
  endtask

  initial begin
    int n, g;
    repeat (2) @(negedge clk);
    en = 1;
    chk("reset_o", o_d[0], 16'h0000);
    chk("reset_busy", 16'(busy_d), 16'h0000);
    chk("reset_finish", 16'(fin_d), 16'h0000);
    reset = 0;
    run_op(0, 0, 8'h0E, 8'h0B, 16'h009A, 6, 5);
    run_op(0, 1, 8'h08, 8'h08, 16'h0040, 6, 0);
    run_op(0, 1, 8'h0D, 8'h05, 16'h00F1, 6, 0);
    run_op(0, 1, 8'h07, 8'h0F, 16'h00F9, 6, 0);
    run_op(3, 0, 8'hFF, 8'h01, 16'h00FF, 3, 0);
    run_op(3, 0, 8'hFF, 8'h00, 16'h0000, 2, 0);
    run_op(1, 1, 8'h08, 8'h08, 16'h0040, 0, 0);
    // second start during RUN must be ignored
    repeat (12) @(negedge clk);
    sgn = 0; A = 8'h0E; B = 8'h0B; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    A = 8'h01; B = 8'h01; start = 1;
    @(negedge clk);
    start = 0;
    n = 3;
    while (!fin_d[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("lockout_product", o_d[0], 16'h009A);
    chk("lockout_latency", 16'(n), 16'd6);
    // start held high: back-to-back operations
    repeat (12) @(negedge clk);
    A = 8'h02; B = 8'h03; start = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fin_d[0] && n < 50);
    chk("held_first_finish", 16'(fin_d[0]), 16'd1);
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!fin_d[0] && g < 50);
    start = 0;
    chk("held_gap", 16'(g), 16'd6);
    chk("held_product", o_d[0], 16'h0006);
    // reset during the second RUN iteration
    repeat (12) @(negedge clk);
    A = 8'h0E; B = 8'h0B; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("abort_o", o_d[0], 16'h0000);
    chk("abort_busy", 16'(busy_d[0]), 16'd0);
    chk("abort_finish", 16'(fin_d[0]), 16'd0);
    reset = 0;
    run_op(0, 0, 8'h03, 8'h03, 16'h0009, 6, 0);
    repeat (600) begin
      @(negedge clk);
      start = $urandom_range(0, 2) == 0;
      sgn = 1'($urandom);
      A = 8'($urandom);
      B = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      reset = $urandom_range(0, 149) == 0;
    end
    start = 0;
    reset = 0;
    repeat (12) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
